// File: rtl/mux_pkg.sv
// Shared definitions for the registered stream multiplexer.
// Holds mode encodings and the rotate-priority pick function.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_N      = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(
    input logic [MAX_N-1:0] valid,
    input logic [3:0]       ptr,
    input int               n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_N; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j -= n;
      if (k < n && !p.found && valid[4'(j)]) begin
        p.found = 1'b1;
        p.idx   = 4'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_rr_stream_pick.sv
// Rotate-priority encoder: first valid channel at or after ptr.
// Purely combinational so it can be exercised on its own.
module rr_priority_pick
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    in_valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  pick_t p;

  always_comb begin
    p     = rr_pick(16'(in_valid), 4'(ptr), N);
    idx   = SELW'(p.idx);
    found = p.found;
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready mux with fixed-select or round-robin grant
// feeding one output register that refills in the cycle it drains.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  localparam int VW = 1 << SELW;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_idx;
  logic            rr_found;
  logic [SELW-1:0] grant;
  logic            granted;
  logic            load;
  logic            xfer;
  logic [VW-1:0]   vpad;

  // Padding lets sel index safely even when sel >= N.
  assign vpad = VW'(in_valid);

  rr_priority_pick #(.N(N)) u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .idx      (rr_idx),
    .found    (rr_found)
  );

  always_comb begin
    grant   = '0;
    granted = 1'b0;
    if (mode == MODE_RR) begin
      grant   = rr_idx;
      granted = rr_found;
    end else if (int'(sel) < N && vpad[sel]) begin
      grant   = sel;
      granted = 1'b1;
    end
  end

  assign load     = !out_valid || out_ready;
  assign xfer     = !rst && load && granted;
  assign in_ready = xfer ? N'(1) << grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= granted;
      if (granted) begin
        out_data <= in_data[grant*WIDTH +: WIDTH];
        out_ch   <= grant;
        if (mode == MODE_RR)
          ptr <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Scoreboard bench: a queue-based reference predicts each accepted word,
// a negedge monitor checks the output register against it.
module tb_mux_rr_stream;
  import mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  logic [5:0]     ready6;
  logic           ov6;
  logic [W-1:0]   od6;
  logic [2:0]     oc6;

  always #5 clk = ~clk;

  mux_rr_stream #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  // Six channels with sel=7: an unreachable select.
  mux_rr_stream #(.N(6), .WIDTH(W)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .mode      (MODE_FIXED),
    .sel       (3'd7),
    .in_valid  (6'h3f),
    .in_data   (in_data[6*W-1:0]),
    .in_ready  (ready6),
    .out_valid (ov6),
    .out_data  (od6),
    .out_ch    (oc6),
    .out_ready (1'b1)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  bit   m_full;
  int   m_ptr;
  int   rst_edges;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL out_unexpected: got ch %0d with empty scoreboard", out_ch);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_ch", out_ch, q[0].ch);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic cycle();
    bit load;
    bit found;
    int g;
    int i;
    logic [N-1:0] er;
    @(negedge clk);
    if (rst) begin
      chk("in_ready_rst", in_ready, 0);
      if (rst_edges > 0) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
      end
    end else begin
      chk("out_valid", out_valid, m_full);
      load  = !m_full || out_ready;
      found = 0;
      g     = 0;
      if (mode) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (!found && in_valid[i]) begin
            found = 1;
            g     = i;
          end
        end
      end else if (int'(sel) < N && in_valid[sel]) begin
        found = 1;
        g     = int'(sel);
      end
      er = (load && found) ? N'(1) << g : '0;
      chk("in_ready", in_ready, er);
      if (load) begin
        if (found) begin
          q.push_back('{in_data[g*W +: W], SW'(g)});
          if (mode) m_ptr = (g + 1) % N;
        end
        m_full = found;
      end
    end
    @(posedge clk);
    if (rst) rst_edges++;
    #1;
  endtask

  task automatic do_reset(int n);
    rst       = 1'b1;
    rst_edges = 0;
    m_full    = 0;
    m_ptr     = 0;
    q.delete();
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    mode      = MODE_FIXED;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    do_reset(3);

    for (int i = 0; i < N; i++) begin
      sel = SW'(i);
      cycle();
    end
    in_valid = '0;
    cycle();

    mode     = MODE_RR;
    in_valid = 8'b1010_0101;
    repeat (12) cycle();

    in_valid = '1;
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (2) cycle();

    mode     = MODE_FIXED;
    sel      = 3'd3;
    in_valid = ~8'h08;
    repeat (4) begin
      cycle();
      chk("n6_in_ready", ready6, 0);
      chk("n6_out_valid", ov6, 0);
    end

    mode     = MODE_RR;
    in_valid = 8'h10;
    cycle();
    out_ready = 1'b0;
    cycle();
    cycle();
    do_reset(2);
    out_ready = 1'b1;
    in_valid  = 8'hE8;
    repeat (3) cycle();

    for (int t = 0; t < 400; t++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      if ($urandom_range(0, 60) == 0) do_reset(2);
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
